dma_ctrl: RTL

Single-channel memory-to-memory DMA engine occupying the 16-byte window 0x7800–0x780F, selected by the address decoder's `dma_ena`. The CPU programs source, destination and count through byte registers, then sets start. The block requests the bus from the Z80 (BUSREQ/BUSACK) and copies bytes one at a time while it owns the bus. It then releases the bus and flags completion.

---
 rtl/dma_pkg.sv | 28 ++
 rtl/dma_regs.sv | 110 +++++++++++
 rtl/dma_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA engine.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_REL
  } state_t;

  localparam logic [3:0] REG_SRC_LO = 4'h0;
  localparam logic [3:0] REG_SRC_HI = 4'h1;
  localparam logic [3:0] REG_DST_LO = 4'h2;
  localparam logic [3:0] REG_DST_HI = 4'h3;
  localparam logic [3:0] REG_CNT_LO = 4'h4;
  localparam logic [3:0] REG_CNT_HI = 4'h5;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  localparam int         STROBE_LEN  = 2;
  localparam logic [1:0] STROBE_LAST = 2'(STROBE_LEN - 1);

endpackage

// File: rtl/dma_regs.sv
// CPU-side register file: write edge detect, working
// SRC/DST/CNT counters, done flag and readback mux.
module dma_regs
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_ena,
  input  logic        memrd,
  input  logic        memwr,
  input  logic [3:0]  reg_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        busy_i,
  input  logic        step_i,
  input  logic        set_done_i,
  output logic        start_o,
  output logic        done_o,
  output logic [15:0] src_o,
  output logic [15:0] dst_o,
  output logic [15:0] cnt_o
);

  logic        wr_q;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        wr_now, we, ctl;

  // Commit a write only on the first clock of a bus cycle.
  assign wr_now  = dma_ena & memwr;
  assign we      = wr_now & ~wr_q;
  assign ctl     = we & (reg_addr == REG_CTRL);
  assign start_o = ctl & cpu_din[CTRL_START]
                 & ~busy_i & (cnt_q != 16'd0);

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (step_i) begin
      src_d = src_q + 16'd1;
      dst_d = dst_q + 16'd1;
      cnt_d = cnt_q - 16'd1;
    end
    if (we && !busy_i) begin
      case (reg_addr)
        REG_SRC_LO: src_d[7:0]  = cpu_din;
        REG_SRC_HI: src_d[15:8] = cpu_din;
        REG_DST_LO: dst_d[7:0]  = cpu_din;
        REG_DST_HI: dst_d[15:8] = cpu_din;
        REG_CNT_LO: cnt_d[7:0]  = cpu_din;
        REG_CNT_HI: cnt_d[15:8] = cpu_din;
        default: ;
      endcase
    end
    if (ctl) begin
      if (cpu_din[CTRL_CLR])
        done_d = 1'b0;
      if (cpu_din[CTRL_START] && !busy_i
          && cnt_q == 16'd0)
        done_d = 1'b1;
    end
    if (set_done_i)
      done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      src_q  <= 16'h0000;
      dst_q  <= 16'h0000;
      cnt_q  <= 16'h0000;
      done_q <= 1'b0;
    end else begin
      wr_q   <= wr_now;
      src_q  <= src_d;
      dst_q  <= dst_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    cpu_dout = 8'h00;
    if (dma_ena && memrd) begin
      case (reg_addr)
        REG_SRC_LO: cpu_dout = src_q[7:0];
        REG_SRC_HI: cpu_dout = src_q[15:8];
        REG_DST_LO: cpu_dout = dst_q[7:0];
        REG_DST_HI: cpu_dout = dst_q[15:8];
        REG_CNT_LO: cpu_dout = cnt_q[7:0];
        REG_CNT_HI: cpu_dout = cnt_q[15:8];
        REG_CTRL: begin
          cpu_dout[STAT_BUSY] = busy_i;
          cpu_dout[STAT_DONE] = done_q;
        end
        default: ;
      endcase
    end
  end

  assign done_o = done_q;
  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/dma_ctrl.sv
// Memory-to-memory DMA: bus arbitration FSM and
// byte-copy datapath driving the master port.
module dma_ctrl
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_ena,
  input  logic        memrd,
  input  logic        memwr,
  input  logic [3:0]  reg_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        busreq_n,
  input  logic        busack_n,
  output logic        dma_master,
  output logic [15:0] m_addr,
  input  logic [7:0]  m_din,
  output logic [7:0]  m_dout,
  output logic        m_mreq_n,
  output logic        m_rd_n,
  output logic        m_wr_n,
  output logic        done_irq
);

  state_t      state_q, state_d;
  logic [1:0]  cyc_q, cyc_d;
  logic [7:0]  data_q, data_d;
  logic        ack1_q, ack2_q;
  logic        busy, step, set_done, start;
  logic [15:0] src, dst, cnt;

  assign busy = (state_q != S_IDLE);

  dma_regs u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .dma_ena    (dma_ena),
    .memrd      (memrd),
    .memwr      (memwr),
    .reg_addr   (reg_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .busy_i     (busy),
    .step_i     (step),
    .set_done_i (set_done),
    .start_o    (start),
    .done_o     (done_irq),
    .src_o      (src),
    .dst_o      (dst),
    .cnt_o      (cnt)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    data_d     = data_q;
    step       = 1'b0;
    set_done   = 1'b0;
    busreq_n   = 1'b1;
    dma_master = 1'b0;
    m_addr     = 16'h0000;
    m_dout     = 8'h00;
    m_mreq_n   = 1'b1;
    m_rd_n     = 1'b1;
    m_wr_n     = 1'b1;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        busreq_n = 1'b0;
        cyc_d    = 2'd0;
        if (!ack2_q) state_d = S_RD;
      end
      S_RD: begin
        busreq_n   = 1'b0;
        dma_master = 1'b1;
        m_addr     = src;
        m_mreq_n   = 1'b0;
        m_rd_n     = 1'b0;
        cyc_d      = cyc_q + 2'd1;
        if (cyc_q == STROBE_LAST) begin
          data_d  = m_din;
          cyc_d   = 2'd0;
          state_d = S_WR;
        end
      end
      S_WR: begin
        busreq_n   = 1'b0;
        dma_master = 1'b1;
        m_addr     = dst;
        m_dout     = data_q;
        m_mreq_n   = 1'b0;
        m_wr_n     = 1'b0;
        cyc_d      = cyc_q + 2'd1;
        if (cyc_q == STROBE_LAST) begin
          step  = 1'b1;
          cyc_d = 2'd0;
          // A dropped BUSACK ends the transfer after this byte.
          if (cnt == 16'd1 || ack2_q) begin
            state_d  = S_REL;
            set_done = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_REL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 2'd0;
      data_q  <= 8'h00;
      ack1_q  <= 1'b1;
      ack2_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      data_q  <= data_d;
      ack1_q  <= busack_n;
      ack2_q  <= ack1_q;
    end
  end

endmodule
